// File: rtl/scoreboard_multi_if.sv
// Player-facing signal bundle of scoreboard_multi: buttons, game control, display and result.
// The slave modport is the scoreboard side; the master modport is the driving side.
interface scoreboard_multi_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SEL_W       = 3
);
  logic [NUM_PLAYERS-1:0] pushbutton_i;
  logic                   new_game_i;
  logic [SEL_W-1:0]       disp_sel_i;
  logic [6:0]             seg_tens_o;
  logic [6:0]             seg_ones_o;
  logic [NUM_PLAYERS-1:0] winner_o;
  logic                   game_over_o;

  modport master (
    output pushbutton_i, new_game_i, disp_sel_i,
    input  seg_tens_o, seg_ones_o, winner_o, game_over_o
  );

  modport slave (
    input  pushbutton_i, new_game_i, disp_sel_i,
    output seg_tens_o, seg_ones_o, winner_o, game_over_o
  );
endinterface

// File: rtl/scoreboard_multi.sv
// N-player scoreboard: per-channel sync/debounce/edge detect, saturating scores, winner FSM and
// two-digit 7-segment display. Define WIN_BY_TWO_EN for deuce play (win needs a two-point lead).
module scoreboard_multi #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned WIN_SCORE   = 21,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SEL_W       = 3
) (
  input  logic                clk_1khz_i,
  input  logic                rst_i,
  scoreboard_multi_if.slave   bus_io
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_MS);

  typedef enum logic [0:0] {StPlay, StOver} state_e;

  logic [NUM_PLAYERS-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, press, win;
  logic [CntW-1:0]        cnt_q [NUM_PLAYERS];
  logic [CntW-1:0]        cnt_d [NUM_PLAYERS];
  logic [6:0]             score_q [NUM_PLAYERS];
  logic [6:0]             score_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] winner_q, winner_d;
  state_e                 state_q, state_d;
  logic [8:0]             blink_q;

  // A level is accepted on the edge after the counter has reached DEBOUNCE_MS.
  always_comb begin
    for (int n = 0; n < int'(NUM_PLAYERS); n++) begin
      deb_d[n] = deb_q[n];
      cnt_d[n] = '0;
      if (sync2_q[n] != deb_q[n]) begin
        if (cnt_q[n] == CntMax) deb_d[n] = sync2_q[n];
        else                    cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

`ifdef WIN_BY_TWO_EN
  always_comb begin
    for (int n = 0; n < int'(NUM_PLAYERS); n++) begin
      win[n] = (score_q[n] >= 7'(WIN_SCORE));
      for (int m = 0; m < int'(NUM_PLAYERS); m++) begin
        if (m != n && ({1'b0, score_q[n]} < ({1'b0, score_q[m]} + 8'd2))) win[n] = 1'b0;
      end
    end
  end
`else
  always_comb begin
    for (int n = 0; n < int'(NUM_PLAYERS); n++) win[n] = (score_q[n] == 7'(WIN_SCORE));
  end
`endif

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    score_d  = score_q;
    if (bus_io.new_game_i) begin
      state_d  = StPlay;
      winner_d = '0;
      for (int n = 0; n < int'(NUM_PLAYERS); n++) score_d[n] = '0;
    end else begin
      unique case (state_q)
        StPlay: begin
          for (int n = 0; n < int'(NUM_PLAYERS); n++) begin
            if (press[n] && score_q[n] != 7'd99) score_d[n] = score_q[n] + 7'd1;
          end
          if (|win) begin
            state_d  = StOver;
            winner_d = win & (~win + NUM_PLAYERS'(1));  // isolate lowest set bit
          end
        end
        StOver: ;
      endcase
    end
  end

  always_ff @(posedge clk_1khz_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      winner_q   <= '0;
      state_q    <= StPlay;
      blink_q    <= '0;
      for (int n = 0; n < int'(NUM_PLAYERS); n++) begin
        cnt_q[n]   <= '0;
        score_q[n] <= '0;
      end
    end else begin
      sync1_q    <= bus_io.pushbutton_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      winner_q   <= winner_d;
      state_q    <= state_d;
      blink_q    <= blink_q + 9'd1;
      for (int n = 0; n < int'(NUM_PLAYERS); n++) begin
        cnt_q[n]   <= cnt_d[n];
        score_q[n] <= score_d[n];
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [6:0] sel_score, tens, ones;
  logic       sel_valid, sel_win;

  always_comb begin
    sel_score = '0;
    sel_win   = 1'b0;
    sel_valid = (32'(bus_io.disp_sel_i) < NUM_PLAYERS);
    for (int unsigned n = 0; n < NUM_PLAYERS; n++) begin
      if (32'(bus_io.disp_sel_i) == n) begin
        sel_score = score_q[n];
        sel_win   = winner_q[n];
      end
    end
    tens = sel_score / 7'd10;
    ones = sel_score % 7'd10;
    if (!sel_valid) begin
      bus_io.seg_tens_o = 7'h40;
      bus_io.seg_ones_o = 7'h40;
    end else if (state_q == StOver && sel_win && blink_q[8]) begin
      bus_io.seg_tens_o = 7'h00;
      bus_io.seg_ones_o = 7'h00;
    end else begin
      bus_io.seg_tens_o = seg7(tens[3:0]);
      bus_io.seg_ones_o = seg7(ones[3:0]);
    end
  end

  assign bus_io.winner_o    = winner_q;
  assign bus_io.game_over_o = (state_q == StOver);

endmodule

// File: tb/tb_scoreboard_multi.sv
// Directed bench for scoreboard_multi: DUT a (WIN_SCORE=21) covers latency/display/reset,
// DUT b (WIN_SCORE=3) covers the winner logic. Both use DEBOUNCE_MS=4.
module tb_scoreboard_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  scoreboard_multi_if #(.NUM_PLAYERS(2), .SEL_W(3)) if_a ();
  scoreboard_multi_if #(.NUM_PLAYERS(2), .SEL_W(3)) if_b ();

  scoreboard_multi #(.NUM_PLAYERS(2), .WIN_SCORE(21), .DEBOUNCE_MS(4), .SEL_W(3)) u_dut_a (
    .clk_1khz_i (clk),
    .rst_i      (rst),
    .bus_io     (if_a)
  );

  scoreboard_multi #(.NUM_PLAYERS(2), .WIN_SCORE(3), .DEBOUNCE_MS(4), .SEL_W(3)) u_dut_b (
    .clk_1khz_i (clk),
    .rst_i      (rst),
    .bus_io     (if_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_a(input logic [1:0] mask);
    if_a.pushbutton_i = mask;
    step(10);
    if_a.pushbutton_i = 2'b00;
    step(10);
  endtask

  task automatic press_b(input logic [1:0] mask);
    if_b.pushbutton_i = mask;
    step(10);
    if_b.pushbutton_i = 2'b00;
    step(10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n_checks++; if (if_a.seg_tens_o !== 7'h3F) $display("FAIL reset_tens_a: got %h want 3f", if_a.seg_tens_o); else n_pass++;
    n_checks++; if (if_a.seg_ones_o !== 7'h3F) $display("FAIL reset_ones_a: got %h want 3f", if_a.seg_ones_o); else n_pass++;
    n_checks++; if (if_a.winner_o !== 2'b00) $display("FAIL reset_winner_a: got %b want 00", if_a.winner_o); else n_pass++;
    n_checks++; if (if_a.game_over_o !== 1'b0) $display("FAIL reset_over_a: got %b want 0", if_a.game_over_o); else n_pass++;
    n_checks++; if (if_b.winner_o !== 2'b00) $display("FAIL reset_winner_b: got %b want 00", if_b.winner_o); else n_pass++;
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL reset_over_b: got %b want 0", if_b.game_over_o); else n_pass++;
  endtask

  // pb0 held from edge 0 must score exactly at edge 7; a 3-cycle pb1 pulse must not.
  task automatic test_latency;
    if_a.disp_sel_i   = 3'd0;
    if_a.pushbutton_i = 2'b11;
    step(3);
    if_a.pushbutton_i = 2'b01;
    step(4);
    n_checks++; if (if_a.seg_ones_o !== 7'h3F) $display("FAIL latency_edge6: got %h want 3f", if_a.seg_ones_o); else n_pass++;
    step(1);
    n_checks++; if (if_a.seg_ones_o !== 7'h06) $display("FAIL latency_edge7: got %h want 06", if_a.seg_ones_o); else n_pass++;
    if_a.pushbutton_i = 2'b00;
    step(20);
    n_checks++; if (if_a.seg_ones_o !== 7'h06) $display("FAIL release_no_score: got %h want 06", if_a.seg_ones_o); else n_pass++;
    if_a.disp_sel_i = 3'd1;
    #1;
    n_checks++; if (if_a.seg_ones_o !== 7'h3F) $display("FAIL glitch_ignored: got %h want 3f", if_a.seg_ones_o); else n_pass++;
  endtask

  task automatic test_display;
    for (int i = 0; i < 12; i++) press_a(2'b10);
    if_a.disp_sel_i = 3'd1;
    #1;
    n_checks++; if (if_a.seg_tens_o !== 7'h06) $display("FAIL disp12_tens: got %h want 06", if_a.seg_tens_o); else n_pass++;
    n_checks++; if (if_a.seg_ones_o !== 7'h5B) $display("FAIL disp12_ones: got %h want 5b", if_a.seg_ones_o); else n_pass++;
    if_a.disp_sel_i = 3'd5;
    #1;
    n_checks++; if (if_a.seg_tens_o !== 7'h40) $display("FAIL dash_tens: got %h want 40", if_a.seg_tens_o); else n_pass++;
    n_checks++; if (if_a.seg_ones_o !== 7'h40) $display("FAIL dash_ones: got %h want 40", if_a.seg_ones_o); else n_pass++;
    if_a.disp_sel_i = 3'd0;
    #1;
    n_checks++; if (if_a.seg_tens_o !== 7'h3F) $display("FAIL p0_tens: got %h want 3f", if_a.seg_tens_o); else n_pass++;
    n_checks++; if (if_a.seg_ones_o !== 7'h06) $display("FAIL p0_ones: got %h want 06", if_a.seg_ones_o); else n_pass++;
  endtask

  // Over 512 cycles the winner's digits are blank for exactly 256 and shown for 256.
  task automatic test_blink(input logic [6:0] ones_exp);
    int n_blank = 0;
    int n_show  = 0;
    if_b.disp_sel_i = 3'd0;
    #1;
    for (int i = 0; i < 512; i++) begin
      if (if_b.seg_ones_o === 7'h00 && if_b.seg_tens_o === 7'h00) n_blank++;
      else if (if_b.seg_ones_o === ones_exp && if_b.seg_tens_o === 7'h3F) n_show++;
      step(1);
    end
    n_checks++; if (n_blank !== 256) $display("FAIL blink_blank: got %0d want 256", n_blank); else n_pass++;
    n_checks++; if (n_show !== 256) $display("FAIL blink_shown: got %0d want 256", n_show); else n_pass++;
  endtask

`ifdef WIN_BY_TWO_EN
  task automatic test_win_by_two;
    if_b.disp_sel_i = 3'd0;
    for (int i = 0; i < 3; i++) press_b(2'b11);
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL deuce_3_3: got %b want 0", if_b.game_over_o); else n_pass++;
    press_b(2'b01);
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL deuce_4_3: got %b want 0", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.seg_ones_o !== 7'h66) $display("FAIL deuce_4_disp: got %h want 66", if_b.seg_ones_o); else n_pass++;
    if_b.pushbutton_i = 2'b01;
    step(8);
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL win2_score_edge: got %b want 0", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.seg_ones_o !== 7'h6D) $display("FAIL win2_score5: got %h want 6d", if_b.seg_ones_o); else n_pass++;
    step(1);
    n_checks++; if (if_b.game_over_o !== 1'b1) $display("FAIL win2_over: got %b want 1", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.winner_o !== 2'b01) $display("FAIL win2_winner: got %b want 01", if_b.winner_o); else n_pass++;
    if_b.pushbutton_i = 2'b00;
    step(10);
    test_blink(7'h6D);
    if_b.new_game_i = 1'b1;
    step(1);
    if_b.new_game_i = 1'b0;
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL win2_newgame: got %b want 0", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.seg_ones_o !== 7'h3F) $display("FAIL win2_newgame_score: got %h want 3f", if_b.seg_ones_o); else n_pass++;
  endtask
`else
  task automatic test_simultaneous_win;
    if_b.disp_sel_i = 3'd0;
    press_b(2'b11);
    press_b(2'b11);
    if_b.pushbutton_i = 2'b11;
    step(8);
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL sim_score_edge: got %b want 0", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.seg_ones_o !== 7'h4F) $display("FAIL sim_score3: got %h want 4f", if_b.seg_ones_o); else n_pass++;
    step(1);
    n_checks++; if (if_b.game_over_o !== 1'b1) $display("FAIL sim_over: got %b want 1", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.winner_o !== 2'b01) $display("FAIL sim_winner: got %b want 01", if_b.winner_o); else n_pass++;
    if_b.pushbutton_i = 2'b00;
    step(10);
    press_b(2'b11);
    if_b.disp_sel_i = 3'd1;
    #1;
    n_checks++; if (if_b.seg_ones_o !== 7'h4F) $display("FAIL frozen_p1: got %h want 4f", if_b.seg_ones_o); else n_pass++;
    test_blink(7'h4F);
    // Button held across new_game must not score again.
    if_b.disp_sel_i   = 3'd0;
    if_b.pushbutton_i = 2'b01;
    step(10);
    if_b.new_game_i = 1'b1;
    step(1);
    if_b.new_game_i = 1'b0;
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL newgame_over: got %b want 0", if_b.game_over_o); else n_pass++;
    n_checks++; if (if_b.winner_o !== 2'b00) $display("FAIL newgame_winner: got %b want 00", if_b.winner_o); else n_pass++;
    n_checks++; if (if_b.seg_ones_o !== 7'h3F) $display("FAIL newgame_score: got %h want 3f", if_b.seg_ones_o); else n_pass++;
    step(20);
    n_checks++; if (if_b.seg_ones_o !== 7'h3F) $display("FAIL held_no_rescore: got %h want 3f", if_b.seg_ones_o); else n_pass++;
    if_b.pushbutton_i = 2'b00;
    step(20);
    press_b(2'b01);
    n_checks++; if (if_b.seg_ones_o !== 7'h06) $display("FAIL fresh_press: got %h want 06", if_b.seg_ones_o); else n_pass++;
  endtask
`endif

  // Reset lands at edge 5 of a press that would otherwise debounce at edge 6.
  task automatic test_reset_mid_press;
    if_a.disp_sel_i   = 3'd0;
    if_a.pushbutton_i = 2'b01;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    if_a.pushbutton_i = 2'b00;
    step(20);
    n_checks++; if (if_a.seg_ones_o !== 7'h3F) $display("FAIL rst_mid_p0: got %h want 3f", if_a.seg_ones_o); else n_pass++;
    n_checks++; if (if_a.seg_tens_o !== 7'h3F) $display("FAIL rst_mid_p0_tens: got %h want 3f", if_a.seg_tens_o); else n_pass++;
    if_a.disp_sel_i = 3'd1;
    #1;
    n_checks++; if (if_a.seg_tens_o !== 7'h3F) $display("FAIL rst_p1_tens: got %h want 3f", if_a.seg_tens_o); else n_pass++;
    n_checks++; if (if_b.game_over_o !== 1'b0) $display("FAIL rst_over_b: got %b want 0", if_b.game_over_o); else n_pass++;
  endtask

  initial begin
    if_a.pushbutton_i = 2'b00;
    if_a.new_game_i   = 1'b0;
    if_a.disp_sel_i   = 3'd0;
    if_b.pushbutton_i = 2'b00;
    if_b.new_game_i   = 1'b0;
    if_b.disp_sel_i   = 3'd0;
    test_reset();
    test_latency();
    test_display();
`ifdef WIN_BY_TWO_EN
    test_win_by_two();
`else
    test_simultaneous_win();
`endif
    test_reset_mid_press();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
